// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: FSM states, money and tube widths.
// MONEY_W is the vending machine's money width as well.
package change_dispenser_pkg;
  localparam int MONEY_W = 12;
  localparam int CNT_W = 4;
  localparam int DEF_COIN1_VAL = 1;
  localparam int DEF_COIN2_VAL = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_FINISH
  } state_t;

  typedef logic [MONEY_W-1:0] money_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/change_dispenser_tube.sv
// coin_tube_counter: saturating up/down tube inventory counter.
// A load coincident with an eject cancels out.
import change_dispenser_pkg::*;

module coin_tube_counter #(
  parameter int DEPTH = 15,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             eject,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_W'(INIT);
    end else if (load && !eject) begin
      if (cnt < CNT_W'(DEPTH))
        cnt <= cnt + 1'b1;
    end else if (eject && !load) begin
      if (cnt != '0)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy two-tube coin payout with timed ejector pulses.
// Define CHANGE_INV_EN for tube inventory tracking; otherwise tubes are unlimited.
import change_dispenser_pkg::*;

module change_dispenser #(
  parameter int COIN1_VAL    = DEF_COIN1_VAL,
  parameter int COIN2_VAL    = DEF_COIN2_VAL,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int TUBE_DEPTH   = 15,
  parameter int TUBE_INIT    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MONEY_W-1:0] amount,
  input  logic               load1,
  input  logic               load2,
  output logic               coin1_out,
  output logic               coin2_out,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [MONEY_W-1:0] remaining,
  output logic [CNT_W-1:0]   tube1_cnt,
  output logic [CNT_W-1:0]   tube2_cnt
);

  localparam money_t C1 = MONEY_W'(COIN1_VAL);
  localparam money_t C2 = MONEY_W'(COIN2_VAL);
  localparam logic [15:0] P_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] G_LAST = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] tmr_q, tmr_d;
  logic        sel2_q, sel2_d;
  money_t      rem_d;
  logic        coin1_d, coin2_d;
  logic        busy_d, done_d, short_d;
  logic        ej1, ej2;
  logic        avail1, avail2;
  logic        short_c;

`ifdef CHANGE_INV_EN
  coin_tube_counter #(
    .DEPTH(TUBE_DEPTH),
    .INIT (TUBE_INIT)
  ) u_tube1 (
    .clk  (clk),
    .rst  (rst),
    .load (load1),
    .eject(ej1),
    .cnt  (tube1_cnt)
  );

  coin_tube_counter #(
    .DEPTH(TUBE_DEPTH),
    .INIT (TUBE_INIT)
  ) u_tube2 (
    .clk  (clk),
    .rst  (rst),
    .load (load2),
    .eject(ej2),
    .cnt  (tube2_cnt)
  );

  assign avail1  = tube1_cnt != '0;
  assign avail2  = tube2_cnt != '0;
  assign short_c = remaining != '0;
`else
  logic unused_inv;

  assign tube1_cnt  = CNT_W'(TUBE_DEPTH);
  assign tube2_cnt  = CNT_W'(TUBE_DEPTH);
  assign avail1     = 1'b1;
  assign avail2     = 1'b1;
  // Only a sub-coin residue can be left over with unlimited tubes.
  assign short_c    = (remaining != '0) && (remaining < C1);
  assign unused_inv = ^{load1, load2, ej1, ej2, 32'(TUBE_INIT)};
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sel2_d  = sel2_q;
    rem_d   = remaining;
    coin1_d = 1'b0;
    coin2_d = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    short_d = 1'b0;
    ej1     = 1'b0;
    ej2     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = amount;
          busy_d  = 1'b1;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        tmr_d = '0;
        if (remaining >= C2 && avail2) begin
          sel2_d  = 1'b1;
          coin2_d = 1'b1;
          state_d = S_PULSE;
        end else if (remaining >= C1 && avail1) begin
          sel2_d  = 1'b0;
          coin1_d = 1'b1;
          state_d = S_PULSE;
        end else begin
          done_d  = 1'b1;
          short_d = short_c;
          state_d = S_FINISH;
        end
      end
      S_PULSE: begin
        if (tmr_q == P_LAST) begin
          tmr_d   = '0;
          rem_d   = remaining - (sel2_q ? C2 : C1);
          ej1     = !sel2_q;
          ej2     = sel2_q;
          state_d = S_GAP;
        end else begin
          tmr_d   = tmr_q + 16'd1;
          coin1_d = !sel2_q;
          coin2_d = sel2_q;
        end
      end
      S_GAP: begin
        if (tmr_q == G_LAST) begin
          tmr_d   = '0;
          state_d = S_SELECT;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      sel2_q    <= 1'b0;
      remaining <= '0;
      coin1_out <= 1'b0;
      coin2_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      sel2_q    <= sel2_d;
      remaining <= rem_d;
      coin1_out <= coin1_d;
      coin2_out <= coin2_d;
      busy      <= busy_d;
      done      <= done_d;
      short     <= short_d;
    end
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of the vending machine. When a refund or change request arrives with the credit value, it ejects coins from two coin tubes: the larger-value coin first, then the smaller. Each ejection is a timed pulse on an ejector drive. It tracks tube inventory and reports any value it could not pay out.

## Interface
Parameters:
- COIN1_VAL, 1: money units per small coin
- COIN2_VAL, 2: money units per large coin (> COIN1_VAL)
- PULSE_CYCLES, 2: ejector drive high time, ≥1
- GAP_CYCLES, 2: all-low gap after each pulse, ≥1
- TUBE_DEPTH, 15: tube capacity; counts are 4 bits wide
- TUBE_INIT, 0: tube count after reset

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  change request; accepted only in IDLE
- amount  in  12  value to return; sampled on an accepted start
- load1  in  1  one-cycle pulse: one small coin added to tube 1
- load2  in  1  one-cycle pulse: one large coin added to tube 2
- coin1_out  out  1  small-coin ejector drive
- coin2_out  out  1  large-coin ejector drive
- busy  out  1  high from the accepted start until FINISH
- done  out  1  one-cycle completion pulse
- short  out  1  valid while done is high; 1 if remaining ≠ 0
- remaining  out  12  value still owed; held after done until the next accepted start
- tube1_cnt  out  4  small-coin inventory
- tube2_cnt  out  4  large-coin inventory

## Operation
- All outputs are registered.
- Reset values: every output is 0, except tube1_cnt and tube2_cnt, which take TUBE_INIT. FSM state resets to IDLE.
- FSM states:
  - IDLE: start → remaining = amount, go to SELECT. Otherwise stay.
  - SELECT:
    - If remaining ≥ COIN2_VAL and tube2_cnt > 0, choose coin 2 and go to PULSE.
    - Else if remaining ≥ COIN1_VAL and tube1_cnt > 0, choose coin 1 and go to PULSE.
    - Else go to FINISH.
  - PULSE: the chosen coinN_out is high for PULSE_CYCLES cycles. In the last PULSE cycle, remaining -= coin value and the chosen tube count -= 1. Then go to GAP.
  - GAP: all coin outputs are low for GAP_CYCLES cycles, then go to SELECT.
  - FINISH: done = 1 and short = (remaining ≠ 0) for one cycle, then go to IDLE.
- The greedy order is fixed. There is no backtracking: a non-exact result is reported through short.
- A start received while busy is ignored; no queueing.
- Load pulses are honoured in every state, including during dispensing:
  - A load saturates at TUBE_DEPTH.
  - A load coincident with a decrement of the same tube leaves the count unchanged.
- remaining arithmetic is unsigned 12-bit. Subtraction occurs only when remaining ≥ the coin value, so remaining never wraps.
- coin1_out and coin2_out are never high together.

## Timing
- Take the start sampling edge as cycle 0:
  - SELECT is in cycle 1.
  - The first pulse is high in cycles 2 … 1+PULSE_CYCLES.
- Each coin costs 1 + PULSE_CYCLES + GAP_CYCLES cycles.
- done is high in cycle k·(1+PULSE_CYCLES+GAP_CYCLES) + 2 for k coins. With the defaults this is 5k + 2; amount = 0 gives done in cycle 2.
- busy rises in cycle 1 and falls in the cycle after done.
- A start in the cycle immediately after FINISH is accepted.
- rst mid-operation immediately forces coin outputs, busy, done, short and remaining to 0, and returns the FSM to IDLE. An ejector pulse is therefore truncated.

## Configuration
- CHANGE_INV_EN defined: inventory tracking, saturation and the tube-empty fallback are as above.
- CHANGE_INV_EN undefined:
  - Tubes are treated as unlimited.
  - tube1_cnt and tube2_cnt read constant TUBE_DEPTH; load pulses are ignored.
  - SELECT ignores tube counts.
  - short is asserted only when the residue is < COIN1_VAL.

## Structure
- Shared package: FSM state encoding (IDLE, SELECT, PULSE, GAP, FINISH), the 12-bit money width, the 4-bit tube-count width, and default coin values. The vending machine's money width is taken from the same constant.
- One natural sub-module: coin_tube_counter, a saturating up/down counter with load and eject inputs, instantiated twice. When CHANGE_INV_EN is undefined it is omitted and the count is tied to the constant.

## Test plan
All scenarios use the defaults (COIN1_VAL=1, COIN2_VAL=2, PULSE_CYCLES=2, GAP_CYCLES=2) with CHANGE_INV_EN defined.
- Exact change: load2 ×3, load1 ×2; start with amount = 5 → coin2 pulses ×2, then coin1 ×1; done in cycle 17; short = 0, remaining = 0, tube2_cnt = 1, tube1_cnt = 1.
- Fallback: tube2 = 0, tube1 = 4; amount = 3 → three coin1 pulses; done in cycle 17; tube1_cnt = 1, short = 0.
- Shortfall: tube2 = 1, tube1 = 0; amount = 5 → one coin2 pulse; done in cycle 7 with short = 1 and remaining = 3, held until the next start.
- Zero amount: amount = 0 → no pulses; done in cycle 2; short = 0; busy high only in cycles 1–2.
- Reset mid-pulse: rst during coin2_out high → coin2_out, busy and remaining are 0 before the next clock edge; tube counts equal TUBE_INIT; FSM is in IDLE.
- Contention:
  - start while busy → ignored; remaining is unchanged.
  - load2 in the last PULSE cycle of a coin2 → tube2_cnt is unchanged.
  - load1 ×20 from 0 → tube1_cnt saturates at 15.
